oram_byte_loader: RTL

- Byte-stream front end that turns a host byte protocol into ORAM backend transactions. It is the successor of the UART program loader.
- Generalised in command, address and data width.
- Adds a read path: read data returned by the ORAM is serialised back to the host.
- Sits between a UART (or any 8-bit valid/ready byte source/sink) and the ORAM command/data interfaces.

---
 rtl/oram_byte_loader_if.sv | 39 +++
 rtl/oram_byte_loader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/oram_byte_loader_if.sv
// Byte-stream and ORAM backend signals of the byte loader, grouped for port connection.
// master is the loader's view; slave is the host/ORAM environment's view.
interface oram_byte_loader_if #(
  parameter int ORAMU      = 32,
  parameter int BECMDWidth = 2,
  parameter int FEDWidth   = 512
);
  logic [7:0]            RxData;
  logic                  RxValid;
  logic                  RxReady;
  logic [7:0]            TxData;
  logic                  TxValid;
  logic                  TxReady;
  logic [BECMDWidth-1:0] ORAMCommand;
  logic [ORAMU-1:0]      ORAMPAddr;
  logic                  ORAMCommandValid;
  logic                  ORAMCommandReady;
  logic [FEDWidth-1:0]   ORAMDataIn;
  logic                  ORAMDataInValid;
  logic                  ORAMDataInReady;
  logic [FEDWidth-1:0]   ORAMDataOut;
  logic                  ORAMDataOutValid;
  logic                  ORAMDataOutReady;
  logic                  Busy;

  modport master (
    input  RxData, RxValid, TxReady, ORAMCommandReady, ORAMDataInReady,
           ORAMDataOut, ORAMDataOutValid,
    output RxReady, TxData, TxValid, ORAMCommand, ORAMPAddr, ORAMCommandValid,
           ORAMDataIn, ORAMDataInValid, ORAMDataOutReady, Busy
  );

  modport slave (
    output RxData, RxValid, TxReady, ORAMCommandReady, ORAMDataInReady,
           ORAMDataOut, ORAMDataOutValid,
    input  RxReady, TxData, TxValid, ORAMCommand, ORAMPAddr, ORAMCommandValid,
           ORAMDataIn, ORAMDataInValid, ORAMDataOutReady, Busy
  );
endinterface

// File: rtl/oram_byte_loader.sv
// Host byte protocol to ORAM command/data front end: parses header/address/write-data
// frames into backend transactions and serialises read data back to the host.
module oram_byte_loader #(
  parameter int                    ORAMU      = 32,
  parameter int                    BECMDWidth = 2,
  parameter int                    FEDWidth   = 512,
  parameter logic [BECMDWidth-1:0] CmdWrite   = BECMDWidth'(0),
  parameter logic [BECMDWidth-1:0] CmdRead    = BECMDWidth'(1)
) (
  input logic                 Clock,
  input logic                 Reset,
  oram_byte_loader_if.master  bus
);
  localparam int AB    = ORAMU / 8;
  localparam int DB    = FEDWidth / 8;
  localparam int MAXB  = (AB > DB) ? AB : DB;
  localparam int CNT_W = $clog2(MAXB) + 1;

  typedef enum logic [2:0] {HDR, ADDR, CMD, WDATA, WISSUE, RWAIT, RSEND} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BECMDWidth-1:0] cmd_q, cmd_d;
  logic [ORAMU-1:0]      addr_q, addr_d;
  logic [FEDWidth-1:0]   data_q, data_d;
  logic                  rx_ready;
  logic                  rx_fire;
  logic [7:0]            tx_byte;

  // RxReady is held low while Reset is asserted so every output reads 0 during reset.
  assign rx_ready = !Reset && (state_q == HDR || state_q == ADDR || state_q == WDATA);
  assign rx_fire  = bus.RxValid && rx_ready;

  always_comb begin
    tx_byte = '0;
    for (int i = 0; i < DB; i++) begin
      if (cnt_q == CNT_W'(i)) tx_byte = data_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      HDR: begin
        if (rx_fire) begin
          cmd_d   = bus.RxData[BECMDWidth-1:0];
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (rx_fire) begin
          for (int i = 0; i < AB; i++) begin
            if (cnt_q == CNT_W'(i)) addr_d[8*i +: 8] = bus.RxData;
          end
          if (cnt_q == CNT_W'(AB - 1)) begin
            cnt_d   = '0;
            state_d = CMD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CMD: begin
        if (bus.ORAMCommandReady) begin
          cnt_d = '0;
          if (cmd_q == CmdWrite)     state_d = WDATA;
          else if (cmd_q == CmdRead) state_d = RWAIT;
          else                       state_d = HDR;
        end
      end
      WDATA: begin
        if (rx_fire) begin
          for (int i = 0; i < DB; i++) begin
            if (cnt_q == CNT_W'(i)) data_d[8*i +: 8] = bus.RxData;
          end
          if (cnt_q == CNT_W'(DB - 1)) begin
            cnt_d   = '0;
            state_d = WISSUE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WISSUE: begin
        if (bus.ORAMDataInReady) state_d = HDR;
      end
      RWAIT: begin
        if (bus.ORAMDataOutValid) begin
          data_d  = bus.ORAMDataOut;
          cnt_d   = '0;
          state_d = RSEND;
        end
      end
      RSEND: begin
        if (bus.TxReady) begin
          if (cnt_q == CNT_W'(DB - 1)) begin
            cnt_d   = '0;
            state_d = HDR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= HDR;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Every valid/ready is a pure decode of the registered state; no ready feeds a valid.
  assign bus.RxReady          = rx_ready;
  assign bus.ORAMCommandValid = (state_q == CMD);
  assign bus.ORAMDataInValid  = (state_q == WISSUE);
  assign bus.ORAMDataOutReady = (state_q == RWAIT);
  assign bus.TxValid          = (state_q == RSEND);
  assign bus.TxData           = tx_byte;
  assign bus.ORAMCommand      = cmd_q;
  assign bus.ORAMPAddr        = addr_q;
  assign bus.ORAMDataIn       = data_q;
  assign bus.Busy             = (state_q != HDR);
endmodule
